// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/allowin/ready_go handshake, flush, and saturating stall/bubble counters.
// Define PIPE_SKID_EN to build a 2-entry skid buffer whose in_allowin is registered.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 64,
  parameter int                 CNT_W    = 16,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_allowin,
  input  logic              ready_go,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_allowin,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
);

  logic              fire_in;
  logic              fire_out;
  logic              head_valid_reg;
  logic [DATA_W-1:0] head_data_reg;
  logic [CNT_W-1:0]  stall_reg;
  logic [CNT_W-1:0]  bubble_reg;

  assign out_valid = head_valid_reg & ready_go;
  assign out_data  = head_data_reg;
  assign fire_in   = in_valid & in_allowin;
  assign fire_out  = out_valid & out_allowin;

`ifdef PIPE_SKID_EN
  logic              skid_valid_reg;
  logic [DATA_W-1:0] skid_data_reg;

  // Upstream only sees the skid flag, so its timing is independent of out_allowin.
  assign in_allowin = !skid_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= RST_DATA;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= RST_DATA;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      case ({fire_out, fire_in})
        2'b11: begin
          if (skid_valid_reg) begin
            head_data_reg <= skid_data_reg;
            skid_data_reg <= in_data;
          end else begin
            head_data_reg <= in_data;
          end
        end
        2'b10: begin
          if (skid_valid_reg) begin
            head_data_reg  <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end else begin
            head_valid_reg <= 1'b0;
          end
        end
        2'b01: begin
          if (head_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
          end else begin
            head_valid_reg <= 1'b1;
            head_data_reg  <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign in_allowin = !head_valid_reg | (ready_go & out_allowin);

  // Payload only moves on a real load, so it stays stable through stalls and empty cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= RST_DATA;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
    end else if (in_allowin) begin
      head_valid_reg <= in_valid;
      if (in_valid) begin
        head_data_reg <= in_data;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg  <= '0;
      bubble_reg <= '0;
    end else if (cnt_clr) begin
      stall_reg  <= '0;
      bubble_reg <= '0;
    end else if (!flush) begin
      if (head_valid_reg && !fire_out && stall_reg != '1) begin
        stall_reg <= stall_reg + 1'b1;
      end
      if (!head_valid_reg && bubble_reg != '1) begin
        bubble_reg <= bubble_reg + 1'b1;
      end
    end
  end

  assign stall_cycles  = stall_reg;
  assign bubble_cycles = bubble_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic against a queue-based model.
module tb_pipe_stage_reg;
  localparam int              DW   = 32;
  localparam int              CW   = 4;
  localparam int              CMAX = 15;
  localparam logic [DW-1:0]   RD   = 32'hDEAD_0001;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_allowin;
  logic          ready_go = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_allowin = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] bubble_cycles;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .RST_DATA(RD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_allowin(in_allowin), .ready_go(ready_go), .out_valid(out_valid),
    .out_data(out_data), .out_allowin(out_allowin), .flush(flush),
    .cnt_clr(cnt_clr), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: entries in FIFO order, plus the last payload seen at the head.
  logic [DW-1:0] q[$];
  logic [DW-1:0] head_m;
  int            stall_m;
  int            bubble_m;

  task automatic model_reset();
    q.delete();
    head_m   = RD;
    stall_m  = 0;
    bubble_m = 0;
  endtask

  function automatic bit exp_allowin();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || (ready_go && out_allowin);
  endfunction

  function automatic bit exp_out_valid();
    return (q.size() > 0) && ready_go;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_out_valid()));
    check({tag, ".in_allowin"}, 32'(in_allowin), 32'(exp_allowin()));
    check({tag, ".out_data"}, out_data, head_m);
    check({tag, ".stall"}, 32'(stall_cycles), 32'(stall_m));
    check({tag, ".bubble"}, 32'(bubble_cycles), 32'(bubble_m));
  endtask

  // Called at posedge+1: drive, check before the edge, advance the model across the edge.
  task automatic step(input string tag, input bit iv, input logic [DW-1:0] id,
                      input bit rg, input bit oa, input bit fl, input bit clr);
    bit fi, fo;
    int sz;
    in_valid = iv; in_data = id; ready_go = rg; out_allowin = oa; flush = fl; cnt_clr = clr;
    #3;
    check_all(tag);
    fi = iv && exp_allowin();
    fo = exp_out_valid() && oa;
    sz = q.size();
    if (fo) $display("xfer %s out data=%08h", tag, head_m);
    if (clr) begin
      stall_m = 0; bubble_m = 0;
    end else if (!fl) begin
      if (sz > 0 && !fo && stall_m < CMAX) stall_m++;
      if (sz == 0 && bubble_m < CMAX) bubble_m++;
    end
    if (fl) q.delete();
    else begin
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(id);
    end
    if (q.size() > 0) head_m = q[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step("idle", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("bubble5", 32'(bubble_cycles), 32'd5);
    check("idle_data", out_data, RD);

    step("stream0", 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stream1", 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stream2", 1'b1, 32'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stream3", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stream4", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

    step("clr", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("loadAB", 1'b1, 32'hAB, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("dstall", 1'b1, 32'hCD, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dstall_cnt", 32'(stall_cycles), 32'd3);
    check("dstall_data", out_data, 32'hAB);
    for (int i = 0; i < 3; i++) step("release", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

    step("load5", 1'b1, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("rg0", 1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rg0_data", out_data, 32'h5);
    for (int i = 0; i < 3; i++) step("rg1", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

    step("load66", 1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 1'b0);
    step("flush_held", 1'b1, 32'h77, 1'b1, 1'b0, 1'b1, 1'b0);
    step("flush_empty", 1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    step("post_flush", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_no77", out_data, 32'h66);

    step("load42", 1'b1, 32'h42, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; out_allowin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) step("sat", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("bubble_sat", 32'(bubble_cycles), 32'd15);
    step("sat_clr", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("bubble_clr", 32'(bubble_cycles), 32'd0);

    if (SKID) begin
      step("skid_push1", 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("skid_push2", 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
      check("skid_full", 32'(in_allowin), 32'd0);
      check("skid_head1", out_data, 32'h1);
      step("skid_pop1", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("skid_head2", out_data, 32'h2);
      step("skid_pop2", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) != 0, $urandom, ($urandom % 4) != 0,
           ($urandom % 3) != 0, ($urandom % 20) == 0, ($urandom % 50) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register (IF/ID/EXE/MEM/WB boundaries) replacing per-stage hand-written registers.
- Carries a DATA_W-bit payload plus a valid bit under a valid/allowin/ready_go handshake.
- Holds the payload while downstream stalls, instead of clearing it to zero.
- Supports flush and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 64, payload width in bits (bundled rd, srcs, control, pc, imm fields).
- CNT_W, 16, width of each performance counter.
- RST_DATA, 0, payload register reset value (DATA_W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream stage has a valid instruction.
- in_data  in  DATA_W  upstream payload.
- in_allowin  out  1  this stage accepts from upstream this cycle.
- ready_go  in  1  this stage's work is complete (e.g. multi-cycle op done, hazard cleared).
- out_valid  out  1  payload valid and ready_go; offered downstream.
- out_data  out  DATA_W  payload to downstream (head entry).
- out_allowin  in  1  downstream accepts this cycle.
- flush  in  1  kill all held entries (branch redirect / exception).
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cycles  out  CNT_W  cycles spent holding a valid entry that did not leave.
- bubble_cycles  out  CNT_W  cycles with no valid entry held.

Behaviour:
- Reset: valid=0 (all entries), payload=RST_DATA, stall_cycles=0, bubble_cycles=0. Hence out_valid=0, in_allowin=1, out_data=RST_DATA. Reset is asynchronous; asserting it mid-stall discards held entries immediately.
- Base mode (single entry; this is the default, the macro below is not defined):
  - out_valid = s_valid & ready_go.
  - in_allowin = !s_valid | (ready_go & out_allowin). This is combinational.
  - fire_in = in_valid & in_allowin.
  - fire_out = out_valid & out_allowin.
- Each rising edge, in priority order:
  - flush: s_valid<=0. Payload is not loaded. flush beats a simultaneous fire_in.
  - else if in_allowin: s_valid<=in_valid. Payload<=in_data only when in_valid=1, so the payload is held when in_valid=0.
  - else: hold everything. Payload stays stable while a stall lasts.
- Latency: 1 cycle from in to out. Throughput: 1 per cycle when ready_go and out_allowin are held at 1.
- Simultaneous fire_in and fire_out: the old entry leaves and the new one is loaded in the same edge, with no bubble.
- ready_go=0 with s_valid=1: out_valid=0, in_allowin=0, entry held. ready_go is ignored when s_valid=0.
- Counters, evaluated each edge when not flush and not cnt_clr:
  - stall_cycles+1 if s_valid & !fire_out.
  - bubble_cycles+1 if !s_valid.
  - Both saturate at 2^CNT_W-1; they do not wrap.
  - cnt_clr sets both to 0 and wins over increment.
  - flush cycles are counted in neither counter.
- out_data always reflects the head payload register, even when out_valid=0.

Optional Feature:
- Macro PIPE_SKID_EN.
- When defined, the stage becomes a 2-entry skid buffer (head + skid) so that in_allowin is registered and timing-decoupled from out_allowin.
- in_allowin = !skid_valid, registered.
- fire_in with head occupied and not fire_out writes the skid entry.
- On fire_out, skid moves to head; if fire_in happens in the same edge, the new data enters the skid when the skid was full, otherwise the head.
- Ordering is strictly FIFO.
- flush clears both entries.
- stall_cycles counts when head_valid & !fire_out.
- When PIPE_SKID_EN is not defined, the base single-entry behaviour applies and in_allowin is combinational.

Test Plan:
- Reset released, in_valid=0 for 5 cycles -> out_valid=0, in_allowin=1, out_data=RST_DATA, bubble_cycles=5, stall_cycles=0.
- Streaming: in_valid=1, in_data=0x10,0x11,0x12 on consecutive cycles, ready_go=1, out_allowin=1 -> out_data 0x10,0x11,0x12 one cycle later, out_valid held at 1, stall_cycles=0.
- Downstream stall: load 0xAB, out_allowin=0 for 3 cycles -> out_data=0xAB stable, in_allowin=0, stall_cycles=3. Then release -> 0xAB accepted once and never duplicated.
- ready_go=0 with valid entry 0x5 for 2 cycles -> out_valid=0, in_allowin=0, entry 0x5 retained. ready_go=1 -> out_valid=1 with out_data=0x5.
- flush asserted together with in_valid=1, in_data=0x77 while holding 0x66 -> next cycle out_valid=0, 0x77 not loaded, 0x66 never delivered. Async rst mid-stall -> all outputs at reset values immediately.
- Saturation and clear: CNT_W=4, 20 bubble cycles -> bubble_cycles=15. cnt_clr together with a bubble -> 0.
- PIPE_SKID_EN: stall downstream, push 0x1 and 0x2 -> in_allowin=0 after the second push. Release -> 0x1 then 0x2 delivered in order.
